// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction control unit.
// Walks each instruction through fetch (T0-T2) and execute (T3-T6),
// producing one-hot bus-source selects, register load enables and the
// ALU operation for the datapath.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; all bus controls inactive
// T0     | PC -> bus, load MAR, compute PC+1 into Z
// T1     | Zlow -> PC, memory read; MDR loads when mem_rdy is high
// T2     | MDR -> IR; undefined ops and HALT finish here
// T3     | Rb -> bus, load Y
// T4     | Rc -> bus, ALU computes op into Z
// T5     | Zlow -> Ra (or LO for the two long-result ops)
// T6     | Zhigh -> HI (long-result ops only)
// HALT   | stopped until reset
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        run,
    input  logic        mem_rdy,
    input  logic [31:0] ir_in,
    output logic [31:0] out_sel,
    output logic [31:0] in_en,
    output logic [5:0]  alu_sel,
    output logic        read,
    output logic        done,
    output logic        illegal,
    output logic        halted
);

    // Bus / register bit positions in out_sel and in_en
    localparam int BIT_HI    = 16;
    localparam int BIT_LO    = 17;
    localparam int BIT_ZHIGH = 18;
    localparam int BIT_ZLOW  = 19;
    localparam int BIT_PC    = 20;
    localparam int BIT_IR    = 21;
    localparam int BIT_MDR   = 22;
    localparam int BIT_MAR   = 23;
    localparam int BIT_Y     = 24;

    localparam logic [5:0] ALU_INC_PC = 6'h20;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_illegal;

    logic [4:0]  w_op;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic        w_op_undef;
    logic        w_op_halt;
    logic        w_op_long;
    logic        w_unused_ir;

    assign w_op = ir_in[31:27];
    assign w_ra = ir_in[26:23];
    assign w_rb = ir_in[22:19];
    assign w_rc = ir_in[18:15];

    // Low IR bits carry immediates the sequencer never looks at
    assign w_unused_ir = ^ir_in[14:0];

    // Opcode classes: 0x10-0x1E undefined, 0x1F halt, 0x0E/0x0F produce a
    // 64-bit result that needs the extra HI write-back cycle
    assign w_op_undef = (w_op >= 5'h10) && (w_op <= 5'h1E);
    assign w_op_halt  = (w_op == 5'h1F);
    assign w_op_long  = (w_op == 5'h0E) || (w_op == 5'h0F);

    // State register; reset drops straight back to IDLE
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Sticky undefined-opcode flag, set on leaving T2 with a bad op
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_illegal <= 1'b0;
        end else if ((r_state == S_T2) && w_op_undef) begin
            r_illegal <= 1'b1;
        end
    end

    // Next-state and Moore-style control decode (only MDR load sees mem_rdy)
    always_comb begin
        w_next  = r_state;
        out_sel = '0;
        in_en   = '0;
        alu_sel = '0;
        read    = 1'b0;
        done    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_T0;
                end
            end

            S_T0: begin
                out_sel[BIT_PC]   = 1'b1;
                in_en[BIT_MAR]    = 1'b1;
                in_en[BIT_ZLOW]   = 1'b1;
                alu_sel           = ALU_INC_PC;
                w_next            = S_T1;
            end

            S_T1: begin
                out_sel[BIT_ZLOW] = 1'b1;
                in_en[BIT_PC]     = 1'b1;
                read              = 1'b1;
                if (mem_rdy) begin
                    in_en[BIT_MDR] = 1'b1;
                    w_next         = S_T2;
                end
            end

            S_T2: begin
                out_sel[BIT_MDR]  = 1'b1;
                in_en[BIT_IR]     = 1'b1;
                if (w_op_halt) begin
                    done   = 1'b1;
                    w_next = S_HALT;
                end else if (w_op_undef) begin
                    done   = 1'b1;
                    w_next = run ? S_T0 : S_IDLE;
                end else begin
                    w_next = S_T3;
                end
            end

            S_T3: begin
                out_sel       = 32'd1 << w_rb;
                in_en[BIT_Y]  = 1'b1;
                w_next        = S_T4;
            end

            S_T4: begin
                out_sel             = 32'd1 << w_rc;
                in_en[BIT_ZLOW]     = 1'b1;
                in_en[BIT_ZHIGH]    = 1'b1;
                alu_sel             = {1'b0, w_op};
                w_next              = S_T5;
            end

            S_T5: begin
                out_sel[BIT_ZLOW] = 1'b1;
                if (w_op_long) begin
                    in_en[BIT_LO] = 1'b1;
                    w_next        = S_T6;
                end else begin
                    in_en  = 32'd1 << w_ra;
                    done   = 1'b1;
                    w_next = run ? S_T0 : S_IDLE;
                end
            end

            S_T6: begin
                out_sel[BIT_ZHIGH] = 1'b1;
                in_en[BIT_HI]      = 1'b1;
                done               = 1'b1;
                w_next             = run ? S_T0 : S_IDLE;
            end

            S_HALT: begin
                w_next = S_HALT;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign illegal = r_illegal;
    assign halted  = (r_state == S_HALT);

endmodule
